// File: rtl/rrat_restore_pkg.sv
// Shared sizing, types and FSM states for the retirement RAT and its commit lanes.
package rrat_restore_pkg;

   localparam int NUM_ARCH_REGS = 32;
   localparam int NUM_PHYS_REGS = 128;
   localparam int INSTR_Q_WIDTH = 4;

   localparam int PHYS_W     = $clog2(NUM_PHYS_REGS);
   localparam int ARCH_W     = $clog2(NUM_ARCH_REGS);
   localparam int ARCH_IDX_W = $clog2(NUM_ARCH_REGS + 1);
   localparam int NZCV_IDX   = NUM_ARCH_REGS;

   typedef logic [PHYS_W-1:0]     phys_idx_t;
   typedef logic [ARCH_IDX_W-1:0] arch_idx_t;

   // One retiring op as the ROB presents it on a commit lane.
   typedef struct packed {
      logic              valid;
      logic              dst_we;
      logic [ARCH_W-1:0] arch_dst;
      phys_idx_t         phys_dst;
      logic              set_nzcv;
      phys_idx_t         phys_nzcv;
   } commit_lane_t;

   typedef enum logic {
      ST_IDLE,
      ST_RESTORE
   } rrat_state_e;

endpackage

// File: rtl/rrat_commit_lane.sv
// One commit lane: applies a single retiring op to the running committed map
// and reports any physical registers that the op supersedes.
module rrat_commit_lane
   import rrat_restore_pkg::*;
#(
   parameter int NUM_ENTRIES = 33,
   parameter int PHYS_W      = 7,
   parameter int ARCH_W      = 5,
   parameter int NZCV_IDX    = 32
) (
   input  logic [NUM_ENTRIES*PHYS_W-1:0] map_in,
   input  logic                          lane_valid,
   input  logic                          dst_we,
   input  logic [ARCH_W-1:0]             arch_dst,
   input  logic [PHYS_W-1:0]             phys_dst,
   input  logic                          set_nzcv,
   input  logic [PHYS_W-1:0]             phys_nzcv,
   output logic [NUM_ENTRIES*PHYS_W-1:0] map_out,
   output logic                          gpr_free,
   output logic [PHYS_W-1:0]             gpr_free_phys,
   output logic                          nzcv_free,
   output logic [PHYS_W-1:0]             nzcv_free_phys
);

   logic [PHYS_W-1:0] old_gpr;
   logic [PHYS_W-1:0] old_nzcv;

   // Look up the previous mappings; a rename to the same phys frees nothing.
   always_comb begin
      map_out        = map_in;
      gpr_free       = 1'b0;
      gpr_free_phys  = '0;
      nzcv_free      = 1'b0;
      nzcv_free_phys = '0;
      old_gpr        = map_in[int'(arch_dst)*PHYS_W +: PHYS_W];
      old_nzcv       = map_in[NZCV_IDX*PHYS_W +: PHYS_W];
      if (lane_valid && dst_we) begin
         if (old_gpr != phys_dst) begin
            gpr_free      = 1'b1;
            gpr_free_phys = old_gpr;
         end
         map_out[int'(arch_dst)*PHYS_W +: PHYS_W] = phys_dst;
      end
      if (lane_valid && set_nzcv) begin
         if (old_nzcv != phys_nzcv) begin
            nzcv_free      = 1'b1;
            nzcv_free_phys = old_nzcv;
         end
         map_out[NZCV_IDX*PHYS_W +: PHYS_W] = phys_nzcv;
      end
   end

endmodule

// File: rtl/rrat_restore.sv
// Retirement RAT: holds the committed arch->phys map (GPRs plus NZCV), frees
// superseded phys registers on commit, and streams the map out after a flush.
module rrat_restore
   import rrat_restore_pkg::*;
#(
   parameter int NUM_ARCH_REGS = rrat_restore_pkg::NUM_ARCH_REGS,
   parameter int NUM_PHYS_REGS = rrat_restore_pkg::NUM_PHYS_REGS,
   parameter int COMMIT_WIDTH  = rrat_restore_pkg::INSTR_Q_WIDTH,
   parameter int RESTORE_LANES = 8,
   localparam int PHYS_W       = $clog2(NUM_PHYS_REGS),
   localparam int ARCH_W       = $clog2(NUM_ARCH_REGS),
   localparam int ARCH_IDX_W   = $clog2(NUM_ARCH_REGS + 1)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [COMMIT_WIDTH-1:0]             commit_valid,
   input  logic [COMMIT_WIDTH-1:0]             commit_dst_we,
   input  logic [COMMIT_WIDTH*ARCH_W-1:0]      commit_arch_dst,
   input  logic [COMMIT_WIDTH*PHYS_W-1:0]      commit_phys_dst,
   input  logic [COMMIT_WIDTH-1:0]             commit_set_nzcv,
   input  logic [COMMIT_WIDTH*PHYS_W-1:0]      commit_phys_nzcv,
   output logic                                commit_ready,
   input  logic                                flush_req,
   output logic [2*COMMIT_WIDTH-1:0]           free_valid,
   output logic [2*COMMIT_WIDTH*PHYS_W-1:0]    free_phys,
   output logic                                restore_valid,
   output logic [ARCH_IDX_W-1:0]               restore_base,
   output logic [RESTORE_LANES-1:0]            restore_lane_valid,
   output logic [RESTORE_LANES*PHYS_W-1:0]     restore_phys,
   output logic                                restore_done
);

   localparam int NUM_ENTRIES = NUM_ARCH_REGS + 1;
   localparam int MAP_W       = NUM_ENTRIES * PHYS_W;
   localparam int NUM_BEATS   = (NUM_ENTRIES + RESTORE_LANES - 1) / RESTORE_LANES;
   localparam int BEAT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   rrat_state_e                   state_q, state_d;
   logic [BEAT_W-1:0]             beat_q, beat_d;
   logic [MAP_W-1:0]              table_q;
   logic [MAP_W-1:0]              map_chain [COMMIT_WIDTH+1];
   logic [2*COMMIT_WIDTH-1:0]     free_valid_d;
   logic [2*COMMIT_WIDTH*PHYS_W-1:0] free_phys_d;
   logic                          last_beat;

   assign commit_ready = (state_q == ST_IDLE);
   assign last_beat    = (beat_q == BEAT_W'(NUM_BEATS - 1));
   assign map_chain[0] = table_q;

   // Lanes are chained oldest-first so a younger lane sees (and frees) an
   // older lane's mapping for the same architectural register.
   for (genvar i = 0; i < COMMIT_WIDTH; i++) begin : g_lane
      rrat_commit_lane #(
         .NUM_ENTRIES (NUM_ENTRIES),
         .PHYS_W      (PHYS_W),
         .ARCH_W      (ARCH_W),
         .NZCV_IDX    (NUM_ARCH_REGS)
      ) u_lane (
         .map_in         (map_chain[i]),
         .lane_valid     (commit_valid[i] & commit_ready),
         .dst_we         (commit_dst_we[i]),
         .arch_dst       (commit_arch_dst[i*ARCH_W +: ARCH_W]),
         .phys_dst       (commit_phys_dst[i*PHYS_W +: PHYS_W]),
         .set_nzcv       (commit_set_nzcv[i]),
         .phys_nzcv      (commit_phys_nzcv[i*PHYS_W +: PHYS_W]),
         .map_out        (map_chain[i+1]),
         .gpr_free       (free_valid_d[2*i]),
         .gpr_free_phys  (free_phys_d[(2*i)*PHYS_W +: PHYS_W]),
         .nzcv_free      (free_valid_d[2*i+1]),
         .nzcv_free_phys (free_phys_d[(2*i+1)*PHYS_W +: PHYS_W])
      );
   end

   // FSM state, beat counter and registered free slots.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         free_valid <= '0;
         free_phys  <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         free_valid <= free_valid_d;
         free_phys  <= free_phys_d;
      end
   end

   // Committed table: identity on reset, updated only while commits are accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int e = 0; e < NUM_ENTRIES; e++) begin
            table_q[e*PHYS_W +: PHYS_W] <= PHYS_W'(e);
         end
      end else if (state_q == ST_IDLE) begin
         table_q <= map_chain[COMMIT_WIDTH];
      end
   end

   // Next state: a flush starts the restore stream, which ends after the last beat.
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         ST_IDLE: begin
            beat_d = '0;
            if (flush_req) begin
               state_d = ST_RESTORE;
            end
         end
         ST_RESTORE: begin
            if (last_beat) begin
               state_d = ST_IDLE;
               beat_d  = '0;
            end else begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            beat_d  = '0;
         end
      endcase
   end

   // Restore beat contents: a window of the table, lanes past NZCV masked to zero.
   always_comb begin
      restore_valid      = 1'b0;
      restore_base       = '0;
      restore_lane_valid = '0;
      restore_phys       = '0;
      restore_done       = 1'b0;
      if (state_q == ST_RESTORE) begin
         restore_valid = 1'b1;
         restore_base  = ARCH_IDX_W'(int'(beat_q) * RESTORE_LANES);
         restore_done  = last_beat;
         for (int k = 0; k < RESTORE_LANES; k++) begin
            if (int'(beat_q) * RESTORE_LANES + k <= NUM_ARCH_REGS) begin
               restore_lane_valid[k] = 1'b1;
               restore_phys[k*PHYS_W +: PHYS_W] =
                  table_q[(int'(beat_q) * RESTORE_LANES + k) * PHYS_W +: PHYS_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_rrat_restore.sv
// Directed bench for rrat_restore: table-driven commit vectors plus hand-written
// flush, restore and reset-during-restore sequences.
module tb_rrat_restore;

   logic        clk;
   logic        rst;
   logic [3:0]  commit_valid;
   logic [3:0]  commit_dst_we;
   logic [19:0] commit_arch_dst;
   logic [27:0] commit_phys_dst;
   logic [3:0]  commit_set_nzcv;
   logic [27:0] commit_phys_nzcv;
   logic        commit_ready;
   logic        flush_req;
   logic [7:0]  free_valid;
   logic [55:0] free_phys;
   logic        restore_valid;
   logic [5:0]  restore_base;
   logic [7:0]  restore_lane_valid;
   logic [55:0] restore_phys;
   logic        restore_done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [3:0]  valid;
      logic [3:0]  we;
      logic [19:0] arch;
      logic [27:0] phys;
      logic [3:0]  nzcv;
      logic [27:0] phys_nzcv;
      logic [7:0]  exp_fv;
      logic [55:0] exp_fp;
   } vec_t;

   vec_t vecs [8];

   rrat_restore dut (
      .clk                (clk),
      .rst                (rst),
      .commit_valid       (commit_valid),
      .commit_dst_we      (commit_dst_we),
      .commit_arch_dst    (commit_arch_dst),
      .commit_phys_dst    (commit_phys_dst),
      .commit_set_nzcv    (commit_set_nzcv),
      .commit_phys_nzcv   (commit_phys_nzcv),
      .commit_ready       (commit_ready),
      .flush_req          (flush_req),
      .free_valid         (free_valid),
      .free_phys          (free_phys),
      .restore_valid      (restore_valid),
      .restore_base       (restore_base),
      .restore_lane_valid (restore_lane_valid),
      .restore_phys       (restore_phys),
      .restore_done       (restore_done)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The ROB must never retire while the map is being streamed out.
   always @(posedge clk) begin
      if (rst && restore_valid && (commit_valid != 4'b0)) begin
         $error("[TB] commit_valid asserted during restore");
      end
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic clearInputs();
      commit_valid     = '0;
      commit_dst_we    = '0;
      commit_arch_dst  = '0;
      commit_phys_dst  = '0;
      commit_set_nzcv  = '0;
      commit_phys_nzcv = '0;
      flush_req        = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      commit_valid     = v.valid;
      commit_dst_we    = v.we;
      commit_arch_dst  = v.arch;
      commit_phys_dst  = v.phys;
      commit_set_nzcv  = v.nzcv;
      commit_phys_nzcv = v.phys_nzcv;
   endtask

   // Committed map expected after the vector table (mode 1) or after reset (mode 0).
   function automatic logic [6:0] expMap(input int idx, input int mode);
      if (mode == 0) return 7'(idx);
      case (idx)
         1:       return 7'd41;
         3:       return 7'd80;
         5:       return 7'd60;
         10:      return 7'd83;
         31:      return 7'd90;
         32:      return 7'd82;
         default: return 7'(idx);
      endcase
   endfunction

   // Called #1 after the edge that entered RESTORE; checks all beats and the return to IDLE.
   task automatic checkRestore(input int mode);
      logic [7:0]  exp_mask;
      logic [55:0] exp_phys;
      for (int b = 0; b < 5; b++) begin
         if (b > 0) begin
            @(posedge clk);
            #1;
         end
         flush_req = (b == 2);
         exp_mask = '0;
         exp_phys = '0;
         for (int k = 0; k < 8; k++) begin
            if (b * 8 + k <= 32) begin
               exp_mask[k] = 1'b1;
               exp_phys[k*7 +: 7] = expMap(b * 8 + k, mode);
            end
         end
         checkOutput($sformatf("rst_valid_b%0d", b), 64'(restore_valid), 64'd1);
         checkOutput($sformatf("ready_low_b%0d", b), 64'(commit_ready), 64'd0);
         checkOutput($sformatf("base_b%0d", b), 64'(restore_base), 64'(b * 8));
         checkOutput($sformatf("mask_b%0d", b), 64'(restore_lane_valid), 64'(exp_mask));
         checkOutput($sformatf("done_b%0d", b), 64'(restore_done), 64'(b == 4));
         checkOutput($sformatf("phys_b%0d", b), 64'(restore_phys), 64'(exp_phys));
      end
      flush_req = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("post_restore_valid", 64'(restore_valid), 64'd0);
      checkOutput("post_restore_ready", 64'(commit_ready), 64'd1);
   endtask

   initial begin
      logic [55:0] fp_mask;

      vecs[0] = '{"x3_to_40", 4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {7'd0, 7'd0, 7'd0, 7'd40},
                  4'b0000, 28'd0, 8'h01, {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd3}};
      vecs[1] = '{"x5_twice", 4'b0101, 4'b0101, {5'd0, 5'd5, 5'd0, 5'd5}, {7'd0, 7'd60, 7'd0, 7'd50},
                  4'b0000, 28'd0, 8'h11, {7'd0, 7'd0, 7'd0, 7'd50, 7'd0, 7'd0, 7'd0, 7'd5}};
      vecs[2] = '{"nzcv_70", 4'b0010, 4'b0000, 20'd0, 28'd0,
                  4'b0010, {7'd0, 7'd0, 7'd70, 7'd0}, 8'h08, {7'd0, 7'd0, 7'd0, 7'd0, 7'd32, 7'd0, 7'd0, 7'd0}};
      vecs[3] = '{"nzcv_same", 4'b0010, 4'b0000, 20'd0, 28'd0,
                  4'b0010, {7'd0, 7'd0, 7'd70, 7'd0}, 8'h00, 56'd0};
      vecs[4] = '{"invalid_lane", 4'b0000, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd7}, {7'd0, 7'd0, 7'd0, 7'd99},
                  4'b0001, {7'd0, 7'd0, 7'd0, 7'd100}, 8'h00, 56'd0};
      vecs[5] = '{"four_lanes", 4'b1111, 4'b0111, {5'd9, 5'd10, 5'd10, 5'd3}, {7'd120, 7'd83, 7'd81, 7'd80},
                  4'b0010, {7'd0, 7'd0, 7'd82, 7'd0}, 8'h1D, {7'd0, 7'd0, 7'd0, 7'd81, 7'd70, 7'd10, 7'd0, 7'd40}};
      vecs[6] = '{"same_phys", 4'b1001, 4'b1001, {5'd0, 5'd0, 5'd0, 5'd31}, {7'd0, 7'd0, 7'd0, 7'd90},
                  4'b0000, 28'd0, 8'h01, {7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd31}};
      vecs[7] = '{"idle", 4'b0000, 4'b0000, 20'd0, 28'd0, 4'b0000, 28'd0, 8'h00, 56'd0};

      // Reset and reset-state checks.
      clearInputs();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_ready", 64'(commit_ready), 64'd1);
      checkOutput("reset_free_valid", 64'(free_valid), 64'd0);
      checkOutput("reset_restore_valid", 64'(restore_valid), 64'd0);

      // Identity restore straight out of reset.
      @(negedge clk);
      flush_req = 1'b1;
      @(posedge clk);
      #1;
      flush_req = 1'b0;
      checkRestore(0);

      // Commit vector table; frees are checked one cycle after each commit.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1;
         clearInputs();
         fp_mask = '0;
         for (int s = 0; s < 8; s++) begin
            if (vecs[i].exp_fv[s]) fp_mask[s*7 +: 7] = 7'h7F;
         end
         checkOutput({vecs[i].name, "_fv"}, 64'(free_valid), 64'(vecs[i].exp_fv));
         checkOutput({vecs[i].name, "_fp"}, 64'(free_phys & fp_mask), 64'(vecs[i].exp_fp));
      end

      // Flush with a same-cycle commit: commit lands first, its free shows in RESTORE.
      @(negedge clk);
      flush_req        = 1'b1;
      commit_valid     = 4'b0001;
      commit_dst_we    = 4'b0001;
      commit_arch_dst  = {5'd0, 5'd0, 5'd0, 5'd1};
      commit_phys_dst  = {7'd0, 7'd0, 7'd0, 7'd41};
      @(posedge clk);
      #1;
      clearInputs();
      checkOutput("flush_fv", 64'(free_valid), 64'h01);
      checkOutput("flush_fp0", 64'(free_phys[6:0]), 64'd1);
      checkOutput("flush_b0_lane1", 64'(restore_phys[13:7]), 64'd41);
      checkRestore(1);

      // Reset asserted during beat 2 aborts the stream at once.
      @(negedge clk);
      flush_req = 1'b1;
      @(posedge clk);
      #1;
      flush_req = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      checkOutput("abort_base_b2", 64'(restore_base), 64'd16);
      rst = 1'b0;
      #1;
      checkOutput("abort_restore_valid", 64'(restore_valid), 64'd0);
      checkOutput("abort_lane_valid", 64'(restore_lane_valid), 64'd0);
      checkOutput("abort_ready", 64'(commit_ready), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_idle_ready", 64'(commit_ready), 64'd1);
      checkOutput("abort_idle_valid", 64'(restore_valid), 64'd0);
      @(negedge clk);
      flush_req = 1'b1;
      @(posedge clk);
      #1;
      flush_req = 1'b0;
      checkRestore(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rrat_restore.md
Name: rrat_restore

Overview:
- Parametrised retirement RAT that holds the committed arch→phys mapping for all GPRs plus NZCV.
- Accepts up to COMMIT_WIDTH in-order retiring ops per cycle and returns superseded physical registers to the free register list (FRL).
- On a pipeline flush, streams its full committed map to the frontend RAT over several beats, so speculative mappings are restored.
- Sits between the ROB commit port, the FRL and the frontend RAT.

Parameters:
- NUM_ARCH_REGS, reg_pkg::NUM_ARCH_REGS (32): architectural GPRs; NZCV occupies index NUM_ARCH_REGS.
- NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS (128): physical register count.
- COMMIT_WIDTH, uop_pkg::INSTR_Q_WIDTH (4): commit lanes per cycle; lane 0 is oldest.
- RESTORE_LANES, 8: map entries emitted per restore beat.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- commit_valid  in  COMMIT_WIDTH  lane carries a retiring op
- commit_dst_we  in  COMMIT_WIDTH  op writes a GPR
- commit_arch_dst  in  COMMIT_WIDTH×$clog2(NUM_ARCH_REGS)  arch destination
- commit_phys_dst  in  COMMIT_WIDTH×PHYS_W  new phys destination
- commit_set_nzcv  in  COMMIT_WIDTH  op writes NZCV
- commit_phys_nzcv  in  COMMIT_WIDTH×PHYS_W  new phys NZCV
- commit_ready  out  1  commits accepted this cycle
- flush_req  in  1  single-cycle flush request from ROB
- free_valid  out  2×COMMIT_WIDTH  slot 2i = lane i GPR free, slot 2i+1 = lane i NZCV free
- free_phys  out  2×COMMIT_WIDTH×PHYS_W  freed phys register per slot
- restore_valid  out  1  restore beat valid
- restore_base  out  ARCH_IDX_W  arch index of lane 0 of the beat
- restore_lane_valid  out  RESTORE_LANES  per-lane valid mask
- restore_phys  out  RESTORE_LANES×PHYS_W  mapping for restore_base+k
- restore_done  out  1  asserted with the final beat

Behaviour:
- Widths and reset state:
  - PHYS_W = $clog2(NUM_PHYS_REGS); ARCH_IDX_W = $clog2(NUM_ARCH_REGS+1).
  - On reset: table[i] = i for i = 0..NUM_ARCH_REGS (NZCV → NUM_ARCH_REGS); all outputs 0 except commit_ready = 1; FSM = IDLE.
- Commit, IDLE state only (commit_ready = 1):
  - Lanes are processed in order 0..COMMIT_WIDTH-1 against a running table copy.
  - For lane i with commit_valid & commit_dst_we: old = running[arch_dst].
    - If old != phys_dst: assert free slot 2i with old.
    - Then running[arch_dst] = phys_dst.
  - NZCV (commit_set_nzcv) follows the same rule on slot 2i+1, index NUM_ARCH_REGS.
  - Same arch dst on lanes i<j in one bundle: lane j frees lane i's phys_dst. The final table holds the youngest mapping.
  - Invalid lanes and unset write-enables produce no free and no update.
  - Free outputs are registered: valid exactly one cycle after commit, 0 otherwise. The FRL always accepts; there is no backpressure.
- Flush FSM (IDLE → RESTORE → IDLE):
  - flush_req in IDLE: that cycle's commits are applied first (they are older), then RESTORE is entered next cycle with beat counter = 0.
  - RESTORE:
    - commit_ready = 0; commit_valid must be 0 (bench assertion); the table is frozen.
    - Each cycle emits restore_valid = 1 and restore_base = beat×RESTORE_LANES.
    - Lane k is valid iff base+k ≤ NUM_ARCH_REGS; restore_phys carries table[base+k], and 0 for invalid lanes.
    - Beats = ceil((NUM_ARCH_REGS+1)/RESTORE_LANES). restore_done is high on the last beat; the FSM returns to IDLE the following cycle.
  - flush_req during RESTORE is ignored.
  - Free outputs from the final IDLE commit still appear in the first RESTORE cycle.
- Reset mid-restore: aborts immediately, clears all outputs, restores the identity map.

Decomposition:
- reg_pkg: PHYS_W/ARCH_IDX_W-derived typedefs (phys_idx_t, arch_idx_t), NZCV_IDX = NUM_ARCH_REGS.
- rob_pkg: commit-lane struct bundling valid/we/dst/phys/nzcv fields for reuse by the ROB.
- Sub-module rrat_commit_lane: combinational single-lane step (running map in → map out plus free slot pair), instantiated COMMIT_WIDTH times in a chain. The FSM and table stay in the top.

Test Plan:
- Reset: release rst → table identity, free_valid = 0, commit_ready = 1. A restore then streams phys 0..32 over 5 beats (RESTORE_LANES = 8); the last beat has mask 8'b0000_0001 and restore_done = 1.
- Lane 0 commits X3 → phys 40 → next cycle free_valid[0] = 1, free_phys[0] = 3; table[3] = 40.
- Lanes 0 and 2 both commit X5, to phys 50 then 60 → slot 0 frees 5, slot 4 frees 50; table[5] = 60.
- Lane 1 sets NZCV to phys 70 → slot 3 frees 32; a re-commit of NZCV to phys 70 → no free.
- flush_req with lane 0 committing X1 → 41 in the same cycle → slot 0 frees 1; commit_ready is low for 5 cycles; restore beat 0 lane 1 = 41.
- Assert rst during restore beat 2 → restore_valid drops immediately; after release, table is identity and FSM is IDLE.
